character_data: RTL and testbench

- Converts PS/2 keyboard scan-code bytes (Set 2) into ASCII characters.
- Keeps the four most recent characters packed in a 32-bit register, newest character in the LSB.
- Sits between the PS/2 receiver (which delivers one byte per ps2_enable pulse) and the Logo command parser/display, which read the packed word.

---
 rtl/character_data.sv | 124 ++++++++++++
 tb/tb_character_data.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/character_data.sv
// PS/2 Set 2 scan-code to ASCII converter.
// Holds the four most recent characters, newest in out[7:0].
module character_data (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  ps2_info,
  input  logic        ps2_enable,
  output logic [31:0] out
);

  localparam logic [7:0] CODE_BREAK  = 8'hF0;
  localparam logic [7:0] CODE_EXT    = 8'hE0;
  localparam logic [7:0] CODE_LSHIFT = 8'h12;
  localparam logic [7:0] CODE_RSHIFT = 8'h59;
  localparam logic [7:0] CODE_BKSP   = 8'h66;

  logic [31:0] out_q, out_d;
  logic        break_q, break_d;
  logic        ext_q, ext_d;
  logic        shift_q, shift_d;

  logic        map_valid;
  logic [7:0]  map_ascii;

  // Scan-code lookup; shift only alters the five punctuation/digit keys.
  always_comb begin
    map_valid = 1'b1;
    map_ascii = 8'h00;
    case (ps2_info)
      8'h1C: map_ascii = 8'h41;
      8'h32: map_ascii = 8'h42;
      8'h21: map_ascii = 8'h43;
      8'h23: map_ascii = 8'h44;
      8'h24: map_ascii = 8'h45;
      8'h2B: map_ascii = 8'h46;
      8'h34: map_ascii = 8'h47;
      8'h33: map_ascii = 8'h48;
      8'h43: map_ascii = 8'h49;
      8'h3B: map_ascii = 8'h4A;
      8'h42: map_ascii = 8'h4B;
      8'h4B: map_ascii = 8'h4C;
      8'h3A: map_ascii = 8'h4D;
      8'h31: map_ascii = 8'h4E;
      8'h44: map_ascii = 8'h4F;
      8'h4D: map_ascii = 8'h50;
      8'h15: map_ascii = 8'h51;
      8'h2D: map_ascii = 8'h52;
      8'h1B: map_ascii = 8'h53;
      8'h2C: map_ascii = 8'h54;
      8'h3C: map_ascii = 8'h55;
      8'h2A: map_ascii = 8'h56;
      8'h1D: map_ascii = 8'h57;
      8'h22: map_ascii = 8'h58;
      8'h35: map_ascii = 8'h59;
      8'h1A: map_ascii = 8'h5A;
      8'h45: map_ascii = shift_q ? 8'h29 : 8'h30;
      8'h16: map_ascii = 8'h31;
      8'h1E: map_ascii = 8'h32;
      8'h26: map_ascii = 8'h33;
      8'h25: map_ascii = 8'h34;
      8'h2E: map_ascii = 8'h35;
      8'h36: map_ascii = 8'h36;
      8'h3D: map_ascii = 8'h37;
      8'h3E: map_ascii = shift_q ? 8'h2A : 8'h38;
      8'h46: map_ascii = shift_q ? 8'h28 : 8'h39;
      8'h29: map_ascii = 8'h20;
      8'h5A: map_ascii = 8'h0D;
      8'h4E: map_ascii = shift_q ? 8'h5F : 8'h2D;
      8'h55: map_ascii = shift_q ? 8'h2B : 8'h3D;
      8'h49: map_ascii = 8'h2E;
      8'h41: map_ascii = 8'h2C;
      8'h54: map_ascii = 8'h5B;
      8'h5B: map_ascii = 8'h5D;
      8'h4A: map_ascii = 8'h2F;
      default: map_valid = 1'b0;
    endcase
  end

  // Prefix bytes take priority, so F0 F0 stays in the release state.
  always_comb begin
    out_d   = out_q;
    break_d = break_q;
    ext_d   = ext_q;
    shift_d = shift_q;
    if (ps2_enable) begin
      if (ps2_info == CODE_BREAK) begin
        break_d = 1'b1;
      end else if (ps2_info == CODE_EXT) begin
        ext_d = 1'b1;
      end else if (break_q) begin
        break_d = 1'b0;
        ext_d   = 1'b0;
        if (ps2_info == CODE_LSHIFT || ps2_info == CODE_RSHIFT) begin
          shift_d = 1'b0;
        end
      end else if (ext_q) begin
        ext_d = 1'b0;
      end else if (ps2_info == CODE_LSHIFT || ps2_info == CODE_RSHIFT) begin
        shift_d = 1'b1;
      end else if (ps2_info == CODE_BKSP) begin
        out_d = {8'h00, out_q[31:8]};
      end else if (map_valid) begin
        out_d = {out_q[23:0], map_ascii};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_q   <= 32'h0;
      break_q <= 1'b0;
      ext_q   <= 1'b0;
      shift_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      break_q <= break_d;
      ext_q   <= ext_d;
      shift_q <= shift_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_character_data.sv
// Scoreboard bench for character_data: stimulus pushes the hand-computed
// expected word, a monitor pops and compares after every clock edge.
module tb_character_data;

  logic        clock;
  logic        reset;
  logic [7:0]  ps2_info;
  logic        ps2_enable;
  logic [31:0] out;

  logic [31:0] exp_q[$];
  string       name_q[$];
  int          total;
  int          bad;

  character_data dut (
    .clock      (clock),
    .reset      (reset),
    .ps2_info   (ps2_info),
    .ps2_enable (ps2_enable),
    .out        (out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic applyStimulus(input logic rst, input logic en,
                               input logic [7:0] info,
                               input logic [31:0] expected,
                               input string tag);
    @(negedge clock);
    reset      = rst;
    ps2_enable = en;
    ps2_info   = info;
    exp_q.push_back(expected);
    name_q.push_back(tag);
  endtask

  task automatic checkOutput(input logic [31:0] expected, input string tag);
    total++;
    if (out !== expected) begin
      bad++;
      $display("[TB] FAIL %s: out=%08h expected=%08h", tag, out, expected);
    end
  endtask

  // Monitor: one expected word per driven cycle, compared just after the edge.
  always @(posedge clock) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [31:0] e;
      string       n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checkOutput(e, n);
    end
  end

  initial begin
    total      = 0;
    bad        = 0;
    reset      = 1'b1;
    ps2_enable = 1'b0;
    ps2_info   = 8'h00;

    applyStimulus(1, 0, 8'h00, 32'h0, "reset0");
    applyStimulus(1, 1, 8'h21, 32'h0, "reset_prio");

    applyStimulus(0, 1, 8'h21, 32'h00000043, "push_C");
    applyStimulus(0, 1, 8'h22, 32'h00004358, "push_X");
    applyStimulus(0, 1, 8'h23, 32'h00435844, "push_D");
    applyStimulus(0, 1, 8'h24, 32'h43584445, "push_E");
    applyStimulus(0, 1, 8'h25, 32'h58444534, "push_4");
    applyStimulus(0, 1, 8'h26, 32'h44453433, "push_3");
    applyStimulus(0, 1, 8'h27, 32'h44453433, "unmapped27");
    applyStimulus(0, 1, 8'h28, 32'h44453433, "unmapped28");

    applyStimulus(1, 0, 8'h00, 32'h0, "reset1");
    applyStimulus(0, 1, 8'h1C, 32'h00000041, "make_A");
    applyStimulus(0, 1, 8'hF0, 32'h00000041, "break");
    applyStimulus(0, 1, 8'h1C, 32'h00000041, "release_A");
    applyStimulus(0, 1, 8'h32, 32'h00004142, "make_B");

    applyStimulus(0, 1, 8'h12, 32'h00004142, "lshift");
    applyStimulus(0, 1, 8'h3E, 32'h0041422A, "shift_star");
    applyStimulus(0, 1, 8'h1C, 32'h41422A41, "shift_letter");
    applyStimulus(0, 1, 8'hF0, 32'h41422A41, "break_shift");
    applyStimulus(0, 1, 8'h12, 32'h41422A41, "release_shift");
    applyStimulus(0, 1, 8'h3E, 32'h422A4138, "unshift_8");

    applyStimulus(1, 0, 8'h00, 32'h0, "reset2");
    applyStimulus(0, 1, 8'h1C, 32'h00000041, "bs_A");
    applyStimulus(0, 1, 8'h32, 32'h00004142, "bs_B");
    applyStimulus(0, 1, 8'h66, 32'h00000041, "bksp1");
    applyStimulus(0, 1, 8'h66, 32'h00000000, "bksp2");
    applyStimulus(0, 1, 8'h66, 32'h00000000, "bksp_empty");
    applyStimulus(0, 1, 8'hE0, 32'h00000000, "ext");
    applyStimulus(0, 1, 8'h75, 32'h00000000, "ext_discard");
    applyStimulus(0, 1, 8'h1C, 32'h00000041, "after_ext");

    applyStimulus(0, 0, 8'h21, 32'h00000041, "hold1");
    applyStimulus(0, 0, 8'h32, 32'h00000041, "hold2");

    applyStimulus(0, 1, 8'h22, 32'h00004158, "pre_reset_X");
    applyStimulus(0, 1, 8'hF0, 32'h00004158, "pre_reset_break");
    applyStimulus(1, 1, 8'h21, 32'h00000000, "reset_mid");
    applyStimulus(0, 1, 8'h21, 32'h00000043, "fresh_C");

    applyStimulus(0, 1, 8'h12, 32'h00000043, "shift2");
    applyStimulus(0, 1, 8'h46, 32'h00004328, "shift_lparen");
    applyStimulus(0, 1, 8'h45, 32'h00432829, "shift_rparen");
    applyStimulus(0, 1, 8'h55, 32'h4328292B, "shift_plus");
    applyStimulus(0, 1, 8'h4E, 32'h28292B5F, "shift_under");
    applyStimulus(0, 1, 8'hF0, 32'h28292B5F, "break_shift2");
    applyStimulus(0, 1, 8'h12, 32'h28292B5F, "release_shift2");
    applyStimulus(0, 1, 8'h4E, 32'h292B5F2D, "minus");
    applyStimulus(0, 1, 8'h5A, 32'h2B5F2D0D, "enter");
    applyStimulus(0, 1, 8'h29, 32'h5F2D0D20, "space");

    applyStimulus(0, 1, 8'hF0, 32'h5F2D0D20, "dbl_break1");
    applyStimulus(0, 1, 8'hF0, 32'h5F2D0D20, "dbl_break2");
    applyStimulus(0, 1, 8'h21, 32'h5F2D0D20, "dbl_break_rel");
    applyStimulus(0, 1, 8'h21, 32'h2D0D2043, "after_dbl");

    applyStimulus(0, 1, 8'h59, 32'h2D0D2043, "rshift");
    applyStimulus(0, 1, 8'h46, 32'h0D204328, "rshift_lparen");
    applyStimulus(0, 1, 8'hF0, 32'h0D204328, "break_rshift");
    applyStimulus(0, 1, 8'h59, 32'h0D204328, "release_rshift");
    applyStimulus(0, 1, 8'h46, 32'h20432839, "nine");

    @(negedge clock);
    ps2_enable = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
